// File: rtl/piano_voice_select_pkg.sv
// Shared types and default timing constants for the piano output stage.
package piano_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
  localparam int DEFAULT_SUSTAIN_CYCLES  = CLK_HZ / 4;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    SUSTAIN
  } voice_state_t;

endpackage

// File: rtl/piano_voice_select_if.sv
// Key/note inputs and voice outputs of the piano output stage.
interface piano_voice_select_if #(
  parameter int NUM_KEYS = 8
) ();

  logic [NUM_KEYS-1:0]         keys;
  logic [NUM_KEYS-1:0]         notes;
  logic                        speaker;
  logic [$clog2(NUM_KEYS)-1:0] active_key;
  logic                        key_valid;
  logic                        note_on;

  modport master (
    output keys, notes,
    input  speaker, active_key, key_valid, note_on
  );

  modport slave (
    input  keys, notes,
    output speaker, active_key, key_valid, note_on
  );

endinterface

// File: rtl/piano_voice_select_key_debouncer.sv
// One raw push-button: 2-flop synchronizer followed by a restart-on-bounce debouncer.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], key};
      if (sync_q[1] == stable) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/piano_voice_select.sv
// Debounces keys, picks the lowest-index pressed key and gates its note onto the speaker.
// Optional sustain after the last release is compiled in when SUSTAIN_EN is defined.
module piano_voice_select
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SUSTAIN_CYCLES  = DEFAULT_SUSTAIN_CYCLES
) (
  input logic                 clk,
  input logic                 reset,
  piano_voice_select_if.slave bus
);

  localparam int KW = $clog2(NUM_KEYS);

  if (NUM_KEYS < 2 || NUM_KEYS > 16) begin : g_bad_num_keys
    $error("NUM_KEYS must be within 2..16");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (SUSTAIN_CYCLES < 1) begin : g_bad_sustain
    $error("SUSTAIN_CYCLES must be at least 1");
  end

  logic [NUM_KEYS-1:0] deb;
  logic [KW-1:0]       pri_idx;
  logic                any;

  voice_state_t  state_q, state_d;
  logic [KW-1:0] sel_q, sel_d;
  logic          note_on_q, note_on_d;
  logic          speaker_q;

`ifdef SUSTAIN_EN
  localparam int SW = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  logic [SW-1:0] sus_cnt_q, sus_cnt_d;
`endif

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset  (reset),
      .key    (bus.keys[i]),
      .stable (deb[i])
    );
  end

  always_comb begin
    pri_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (deb[i]) pri_idx = KW'(i);
    end
  end

  assign any = |deb;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    note_on_d = 1'b0;
`ifdef SUSTAIN_EN
    sus_cnt_d = sus_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d   = PLAY;
          sel_d     = pri_idx;
          note_on_d = 1'b1;
        end
      end
      PLAY: begin
        if (!any) begin
`ifdef SUSTAIN_EN
          state_d   = SUSTAIN;
          sus_cnt_d = SW'(SUSTAIN_CYCLES - 1);
`else
          state_d   = IDLE;
`endif
        end else if (pri_idx != sel_q) begin
          sel_d     = pri_idx;
          note_on_d = 1'b1;
        end
      end
`ifdef SUSTAIN_EN
      // A press during sustain always counts as a new note, even the same key.
      SUSTAIN: begin
        if (any) begin
          state_d   = PLAY;
          sel_d     = pri_idx;
          note_on_d = 1'b1;
        end else if (sus_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          sus_cnt_d = sus_cnt_q - 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      note_on_q <= 1'b0;
      speaker_q <= 1'b0;
`ifdef SUSTAIN_EN
      sus_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      note_on_q <= note_on_d;
      speaker_q <= (state_q != IDLE) && bus.notes[sel_q];
`ifdef SUSTAIN_EN
      sus_cnt_q <= sus_cnt_d;
`endif
    end
  end

  assign bus.speaker    = speaker_q;
  assign bus.active_key = sel_q;
  assign bus.key_valid  = (state_q != IDLE);
  assign bus.note_on    = note_on_q;

endmodule

// File: tb/tb_piano_voice_select.sv
// Directed bench for piano_voice_select: DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=10, NUM_KEYS=8.
// Expectations follow SUSTAIN_EN, which must match the RTL build.
module tb_piano_voice_select;

  logic       clk;
  logic       reset;
  logic [7:0] notesAtEdge;
  int         cyc;
  int         checkCount;
  int         errorCount;

  piano_voice_select_if #(.NUM_KEYS(8)) bus ();

  piano_voice_select #(
    .NUM_KEYS        (8),
    .DEBOUNCE_CYCLES (4),
    .SUSTAIN_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // notes[i] toggles every i+2 cycles; changes land on the falling edge.
  initial begin
    cyc       = 0;
    bus.notes = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 8; i++) bus.notes[i] = ((cyc / (i + 2)) % 2) == 1;
    end
  end

  initial begin
    notesAtEdge = '0;
    forever begin
      @(posedge clk);
      notesAtEdge = bus.notes;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] k);
    bus.keys = k;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    applyStimulus(8'h00);
    tick(3);
    checkOutput("reset_speaker", 32'(bus.speaker), 0);
    checkOutput("reset_active_key", 32'(bus.active_key), 0);
    checkOutput("reset_key_valid", 32'(bus.key_valid), 0);
    checkOutput("reset_note_on", 32'(bus.note_on), 0);
    reset = 1'b0;
    tick(1);

    $display("[TB] clean press of key 3");
    applyStimulus(8'h08);
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      if (e == 6) begin
        checkOutput("press_early_note_on", 32'(bus.note_on), 0);
        checkOutput("press_early_valid", 32'(bus.key_valid), 0);
      end
      if (e == 7) begin
        checkOutput("press_note_on", 32'(bus.note_on), 1);
        checkOutput("press_active_key", 32'(bus.active_key), 3);
        checkOutput("press_valid", 32'(bus.key_valid), 1);
      end
      if (e == 8) checkOutput("press_note_on_single", 32'(bus.note_on), 0);
      if (e >= 8) checkOutput("press_speaker", 32'(bus.speaker), 32'(notesAtEdge[3]));
    end

    $display("[TB] release of the only key");
    applyStimulus(8'h00);
    for (int e = 1; e <= 20; e++) begin
      tick(1);
`ifdef SUSTAIN_EN
      if (e == 16) checkOutput("sustain_valid_last", 32'(bus.key_valid), 1);
      if (e == 17) begin
        checkOutput("sustain_valid_end", 32'(bus.key_valid), 0);
        checkOutput("sustain_speaker_tail", 32'(bus.speaker), 32'(notesAtEdge[3]));
      end
      if (e == 18) checkOutput("sustain_speaker_off", 32'(bus.speaker), 0);
`else
      if (e == 6) checkOutput("release_valid_hold", 32'(bus.key_valid), 1);
      if (e == 7) checkOutput("release_valid_drop", 32'(bus.key_valid), 0);
      if (e == 8) checkOutput("release_speaker_off", 32'(bus.speaker), 0);
`endif
    end

    $display("[TB] bouncing press of key 3");
    applyStimulus(8'h08);
    tick(2);
    applyStimulus(8'h00);
    tick(2);
    applyStimulus(8'h08);
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (e == 3) checkOutput("bounce_valid_mid", 32'(bus.key_valid), 0);
      if (e == 6) begin
        checkOutput("bounce_valid_late", 32'(bus.key_valid), 0);
        checkOutput("bounce_note_on_late", 32'(bus.note_on), 0);
      end
      if (e == 7) begin
        checkOutput("bounce_note_on", 32'(bus.note_on), 1);
        checkOutput("bounce_active_key", 32'(bus.active_key), 3);
      end
    end
    applyStimulus(8'h00);
    tick(25);

    $display("[TB] priority switch between keys 5 and 2");
    applyStimulus(8'h20);
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (e == 7) begin
        checkOutput("prio5_note_on", 32'(bus.note_on), 1);
        checkOutput("prio5_active_key", 32'(bus.active_key), 5);
      end
    end
    applyStimulus(8'h24);
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 6) begin
        checkOutput("prio2_pre_active", 32'(bus.active_key), 5);
        checkOutput("prio2_pre_note_on", 32'(bus.note_on), 0);
      end
      if (e == 7) begin
        checkOutput("prio2_note_on", 32'(bus.note_on), 1);
        checkOutput("prio2_active_key", 32'(bus.active_key), 2);
      end
      if (e == 8) checkOutput("prio2_note_on_single", 32'(bus.note_on), 0);
      if (e >= 8) checkOutput("prio2_speaker", 32'(bus.speaker), 32'(notesAtEdge[2]));
    end
    applyStimulus(8'h20);
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 7) begin
        checkOutput("back5_note_on", 32'(bus.note_on), 1);
        checkOutput("back5_active_key", 32'(bus.active_key), 5);
      end
      if (e == 8) begin
        checkOutput("back5_note_on_single", 32'(bus.note_on), 0);
        checkOutput("back5_valid", 32'(bus.key_valid), 1);
      end
      if (e >= 9) checkOutput("back5_speaker", 32'(bus.speaker), 32'(notesAtEdge[5]));
    end
    applyStimulus(8'h00);
    tick(25);

    $display("[TB] simultaneous press of keys 4 and 6");
    applyStimulus(8'h50);
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      if (e == 7) begin
        checkOutput("simul_note_on", 32'(bus.note_on), 1);
        checkOutput("simul_active_key", 32'(bus.active_key), 4);
      end
      if (e == 8) begin
        checkOutput("simul_note_on_single", 32'(bus.note_on), 0);
        checkOutput("simul_active_hold", 32'(bus.active_key), 4);
      end
    end

    $display("[TB] release then re-press key 4");
    applyStimulus(8'h00);
    tick(8);
    applyStimulus(8'h10);
    for (int e = 1; e <= 8; e++) begin
      tick(1);
`ifdef SUSTAIN_EN
      if (e == 6) checkOutput("repress_sustain_valid", 32'(bus.key_valid), 1);
`endif
      if (e == 7) begin
        checkOutput("repress_note_on", 32'(bus.note_on), 1);
        checkOutput("repress_active_key", 32'(bus.active_key), 4);
        checkOutput("repress_valid", 32'(bus.key_valid), 1);
      end
      if (e == 8) checkOutput("repress_note_on_single", 32'(bus.note_on), 0);
    end

    $display("[TB] reset mid-note with key 4 held");
    tick(3);
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_speaker", 32'(bus.speaker), 0);
    checkOutput("midreset_valid", 32'(bus.key_valid), 0);
    checkOutput("midreset_active_key", 32'(bus.active_key), 0);
    checkOutput("midreset_note_on", 32'(bus.note_on), 0);
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 6) begin
        checkOutput("redebounce_valid_early", 32'(bus.key_valid), 0);
        checkOutput("redebounce_speaker_early", 32'(bus.speaker), 0);
      end
      if (e == 7) begin
        checkOutput("redebounce_note_on", 32'(bus.note_on), 1);
        checkOutput("redebounce_active_key", 32'(bus.active_key), 4);
        checkOutput("redebounce_valid", 32'(bus.key_valid), 1);
      end
      if (e >= 9) checkOutput("redebounce_speaker", 32'(bus.speaker), 32'(notesAtEdge[4]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
